// File: rtl/hazard_pkg.sv
// Shared opcode map and source-usage defaults for the register hazard scoreboard.
package hazard_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_LW  = 8;
    localparam int OP_SW  = 9;
    localparam int OP_BR  = 10;

    localparam int          STORE_OP_DEF  = OP_SW;
    localparam logic [15:0] USE1_MASK_DEF = 16'h03FF;
    localparam logic [15:0] USE2_MASK_DEF = 16'h040F;

    // Opcodes beyond the 16-entry usage masks read no sources.
    function automatic logic op_uses_src(input logic [15:0] mask, input logic [31:0] op);
        logic used_s;
        if (op < 32'd16) begin
            used_s = mask[op[3:0]];
        end else begin
            used_s = 1'b0;
        end
        return used_s;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One pending-latency counter: flush clear, producer load, and per-cycle countdown.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load_en,
    input  logic [LW-1:0] load_val,
    output logic [LW-1:0] count,
    output logic          busy
);

    logic [LW-1:0] cnt_r;
    logic [LW-1:0] cnt_nxt_s;
    logic          busy_r;

    // Next count: flush beats a load, and a load beats the countdown.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = {LW{1'b0}};
        end else if (load_en) begin
            cnt_nxt_s = load_val;
        end else if (cnt_r != {LW{1'b0}}) begin
            cnt_nxt_s = cnt_r - LW'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and its busy flag, both registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {LW{1'b0}};
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != {LW{1'b0}});
        end
    end

    assign count = cnt_r;
    assign busy  = busy_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard with per-register pending latency and stall statistics.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int          NREG      = 16,
    parameter int          OPW       = 4,
    parameter int          LW        = 2,
    parameter int          CW        = 16,
    parameter logic [15:0] USE1_MASK = USE1_MASK_DEF,
    parameter logic [15:0] USE2_MASK = USE2_MASK_DEF,
    parameter int          STORE_OP  = STORE_OP_DEF,
    localparam int         AW        = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [OPW-1:0]  issue_op,
    input  logic [AW-1:0]   issue_raddr1,
    input  logic [AW-1:0]   issue_raddr2,
    input  logic [AW-1:0]   issue_waddr,
    input  logic            issue_wen,
    input  logic [LW-1:0]   issue_lat,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_mask,
    output logic [CW-1:0]   stall_count
);

    localparam logic [CW-1:0] SCNT_MAX = {CW{1'b1}};

    logic [LW-1:0]   cnt_s [NREG];
    logic [NREG-1:0] busy_s;
    logic [31:0]     op_ext_s;
    logic            is_store_s;
    logic            use1_s;
    logic            use2_s;
    logic            hz1_s;
    logic            hz2_s;
    logic            stall_s;
    logic            accept_s;
    logic            wr_en_s;
    logic [CW-1:0]   stall_cnt_r;

    // Source hazard detection; store data may take a one-cycle mem-to-mem forward.
    always_comb begin
        op_ext_s   = 32'(issue_op);
        is_store_s = (op_ext_s == 32'(STORE_OP));
        use1_s     = op_uses_src(USE1_MASK, op_ext_s);
        use2_s     = op_uses_src(USE2_MASK, op_ext_s) || is_store_s;
        hz1_s      = use1_s && (cnt_s[issue_raddr1] != {LW{1'b0}});
        if (is_store_s) begin
            hz2_s = use2_s && (cnt_s[issue_raddr2] > LW'(1'b1));
        end else begin
            hz2_s = use2_s && (cnt_s[issue_raddr2] != {LW{1'b0}});
        end
        stall_s  = issue_valid && !flush && (hz1_s || hz2_s);
        accept_s = issue_valid && !flush && !stall_s;
        wr_en_s  = accept_s && issue_wen && (issue_waddr != {AW{1'b0}});
    end

    assign cnt_s[0]  = {LW{1'b0}};
    assign busy_s[0] = 1'b0;

    // A zero-latency load clears the entry, so the newest producer always wins.
    for (genvar r = 1; r < NREG; r++) begin : g_entry
        hazard_sb_entry #(
            .LW (LW)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (flush),
            .load_en  (wr_en_s && (issue_waddr == AW'(r))),
            .load_val (issue_lat),
            .count    (cnt_s[r]),
            .busy     (busy_s[r])
        );
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (stall_s && (stall_cnt_r != SCNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CW'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall       = stall_s;
    assign busy_mask   = busy_s;
    assign stall_count = stall_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Parameters
REQ-001 The block SHALL have parameter NREG, default 16, giving the number of architectural registers (AW = clog2(NREG) address bits).
REQ-002 The block SHALL have parameter OPW, default 4, giving the opcode width.
REQ-003 The block SHALL have parameter LW, default 2, giving the latency-counter width; max pending latency is 2^LW-1.
REQ-004 The block SHALL have parameter CW, default 16, giving the stall-counter width.
REQ-005 The block SHALL have parameter USE1_MASK, default 16'h03FF, where bit k=1 means opcode k reads raddr1.
REQ-006 The block SHALL have parameter USE2_MASK, default 16'h040F, where bit k=1 means opcode k reads raddr2.
REQ-007 The block SHALL have parameter STORE_OP, default 9, naming the opcode whose raddr2 may be mem-to-mem forwarded.

Interface
REQ-008 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode-stage instruction present.
- issue_op  in  OPW  opcode.
- issue_raddr1, issue_raddr2  in  AW  source registers.
- issue_waddr  in  AW  destination register.
- issue_wen  in  1  instruction writes the register file.
- issue_lat  in  LW  cycles until result is forwardable; 0 = ALU-forwardable.
- flush  in  1  kill in-flight state (branch or redirect).
- stall  out  1  hold decode this cycle.
- busy_mask  out  NREG  bit r=1 while register r is pending.
- stall_count  out  CW  saturating count of stalled cycles.

Function
REQ-009 The block SHALL hold one LW-bit pending counter per register 1..NREG-1; register 0 SHALL never be pending.
REQ-010 stall SHALL be combinational: it is 1 iff issue_valid=1, flush=0, and any used source has a nonzero counter.
REQ-011 Source 1 SHALL be used when USE1_MASK[issue_op]=1; source 2 SHALL be used when USE2_MASK[issue_op]=1.
REQ-012 Exception: when issue_op=STORE_OP, source 2 SHALL NOT stall if its counter equals 1 (mem-to-mem forward); it SHALL stall if the counter is greater than 1.
REQ-013 An issue SHALL be accepted on a clock edge where issue_valid=1, stall=0 and flush=0.
REQ-014 On acceptance with issue_wen=1, issue_waddr!=0 and issue_lat>0, counter[issue_waddr] SHALL be loaded with issue_lat at that edge.
REQ-015 On every edge, each other nonzero counter SHALL decrement by 1; a load in the same edge SHALL take priority over the decrement of the same entry.
REQ-016 An accepted write with issue_lat=0 SHALL clear counter[issue_waddr] (WAW: the newer producer wins).
REQ-017 flush=1 SHALL zero all counters at the next edge, and no issue SHALL be accepted in that cycle.
REQ-018 busy_mask[r] SHALL equal (counter[r]!=0) and SHALL be registered-state derived, with no combinational path from the issue inputs.
REQ-019 stall_count SHALL increment on each edge where stall=1 and SHALL hold at 2^CW-1 once it saturates.
REQ-020 An out-of-range opcode (issue_op >= 16) SHALL be treated as using no sources.

Reset
REQ-021 While rst_n=0, all counters, busy_mask and stall_count SHALL be 0 immediately (asynchronously), and stall SHALL be 0.
REQ-022 Reset asserted mid-countdown SHALL discard all pending state; the first edge after release SHALL behave as an empty scoreboard.

Structure
REQ-023 Opcode constants, STORE_OP and the default USE masks SHALL live in a shared package, hazard_pkg.
REQ-024 One sub-module, hazard_sb_entry (single counter with load, decrement and clear), SHALL be instantiated NREG-1 times via generate.

Verification
REQ-025 The bench SHALL cover this load-use case: accept op=8 (LW) with waddr=3, lat=1; next cycle op=0 with raddr1=3 -> stall=1 for one cycle, then 0; stall_count=1.
REQ-026 The bench SHALL cover this store-forward case: LW r5 with lat=1; next cycle op=9 (SW) with raddr2=5, raddr1=2 -> stall=0. The same sequence with lat=2 -> stall=1 for exactly one cycle.
REQ-027 The bench SHALL cover writes to register 0: LW r0 with lat=3, then op=0 with raddr1=0 -> stall=0 and busy_mask=0.
REQ-028 The bench SHALL cover flush: LW r4 with lat=3; flush=1 next cycle -> busy_mask=0 the following cycle, and a reader of r4 does not stall.
REQ-029 The bench SHALL cover WAW: LW r6 with lat=3, then op=0 with waddr=6, lat=0 accepted -> busy_mask[6]=0 on the next edge.
REQ-030 The bench SHALL cover reset and saturation: with CW=2, hold a stalling reader for 5 cycles -> stall_count=3; rst_n=0 mid-count -> stall_count=0 and busy_mask=0 asynchronously.
